// File: rtl/system_ctl_regbank_if.sv
// AXI4-Lite bus bundle for system_ctl_regbank.
// The master modport is the PS/interconnect side; the slave modport is the register bank.
interface system_ctl_regbank_if #(
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned DATA_W = 32
);
  logic [ADDR_W-1:0]   awaddr;
  logic [2:0]          awprot;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;
  logic [ADDR_W-1:0]   araddr;
  logic [2:0]          arprot;
  logic                arvalid;
  logic                arready;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rvalid;
  logic                rready;

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    output araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    input  araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/system_ctl_regbank.sv
// AXI4-Lite control/status register bank with read-only status words, byte strobes,
// self-clearing pulse registers and SLVERR on unmapped word indices.
// Optional: define SYSTEM_CTL_REGBANK_ID_EN to map a read-only ID word at index NUM_REGS.
module system_ctl_regbank #(
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 6,
  parameter int unsigned NUM_REGS           = 8,
  parameter logic [15:0] RO_MASK            = 16'h0000,
  parameter logic [15:0] PULSE_MASK         = 16'h0000,
  parameter logic [31:0] RESET_VALUE        = 32'h0000_0000,
  parameter logic [31:0] ID_VALUE           = 32'h5C71_0001
) (
  input  logic                                   S_AXI_ACLK,
  input  logic                                   S_AXI_ARESET,
  system_ctl_regbank_if.slave                    bus,
  output logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] ctl_out,
  output logic [NUM_REGS-1:0]                    ctl_wr_stb,
  input  logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] status_in
);
  localparam int unsigned Dw       = C_S_AXI_DATA_WIDTH;
  localparam int unsigned IdxW     = C_S_AXI_ADDR_WIDTH - 2;
  localparam int unsigned NumIdx   = 2 ** IdxW;
  localparam int unsigned NumBytes = Dw / 8;
`ifdef SYSTEM_CTL_REGBANK_ID_EN
  localparam bit IdEn = 1'b1;
`else
  localparam bit IdEn = 1'b0;
`endif
  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlvErr = 2'b10;

  logic                aw_full_q;
  logic [IdxW-1:0]     aw_idx_q;
  logic                w_full_q;
  logic [Dw-1:0]       w_data_q;
  logic [NumBytes-1:0] w_strb_q;
  logic                bvalid_q;
  logic [1:0]          bresp_q;
  logic                rvalid_q;
  logic [1:0]          rresp_q;
  logic [Dw-1:0]       rdata_q;
  logic [Dw-1:0]       wr_mask;
  logic [Dw-1:0]       rd_word [NumIdx];
  logic                rd_err  [NumIdx];
  logic [IdxW-1:0]     ar_idx;
  logic                aw_hs, w_hs, ar_hs, commit;

  // Protection bits and byte offsets carry no meaning for word registers.
  logic unused_bits;
  assign unused_bits = ^{bus.awprot, bus.arprot, bus.awaddr[1:0], bus.araddr[1:0]};

  assign bus.awready = !S_AXI_ARESET && !aw_full_q && !bvalid_q;
  assign bus.wready  = !S_AXI_ARESET && !w_full_q && !bvalid_q;
  assign bus.arready = !S_AXI_ARESET && !rvalid_q;
  assign bus.bvalid  = bvalid_q;
  assign bus.bresp   = bresp_q;
  assign bus.rvalid  = rvalid_q;
  assign bus.rresp   = rresp_q;
  assign bus.rdata   = rdata_q;

  assign aw_hs  = bus.awvalid && bus.awready;
  assign w_hs   = bus.wvalid && bus.wready;
  assign ar_hs  = bus.arvalid && bus.arready;
  assign commit = aw_full_q && w_full_q && !bvalid_q;
  assign ar_idx = bus.araddr[C_S_AXI_ADDR_WIDTH-1:2];

  for (genvar b = 0; b < NumBytes; b++) begin : g_mask
    assign wr_mask[8*b +: 8] = {8{w_strb_q[b]}};
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg
    logic [Dw-1:0] reg_q, reg_d;
    logic          stb_q;
    logic          hit;

    assign hit = commit && (aw_idx_q == IdxW'(g)) && !RO_MASK[g];

    // Next value: pulse registers fall back to zero every cycle, RW registers hold.
    always_comb begin
      reg_d = PULSE_MASK[g] ? '0 : reg_q;
      if (hit) begin
        reg_d = PULSE_MASK[g] ? (w_data_q & wr_mask)
                              : ((reg_q & ~wr_mask) | (w_data_q & wr_mask));
      end
    end

    // Register storage and its one-cycle write strobe.
    always_ff @(posedge S_AXI_ACLK) begin
      if (S_AXI_ARESET) begin
        reg_q <= PULSE_MASK[g] ? '0 : RESET_VALUE;
        stb_q <= 1'b0;
      end else begin
        reg_q <= reg_d;
        stb_q <= hit;
      end
    end

    assign ctl_out[Dw*g +: Dw] = RO_MASK[g] ? '0 : reg_q;
    assign ctl_wr_stb[g]       = stb_q;
    assign rd_word[g]          = RO_MASK[g] ? status_in[Dw*g +: Dw]
                                            : (PULSE_MASK[g] ? '0 : reg_q);
    assign rd_err[g]           = 1'b0;
  end

  for (genvar g = NUM_REGS; g < NumIdx; g++) begin : g_unmapped
    if (IdEn && (g == NUM_REGS)) begin : g_id
      assign rd_word[g] = ID_VALUE;
      assign rd_err[g]  = 1'b0;
    end else begin : g_err
      assign rd_word[g] = '0;
      assign rd_err[g]  = 1'b1;
    end
  end

  // Write path: independent AW/W holders, commit once both are full and B is free.
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      aw_full_q <= 1'b0;
      aw_idx_q  <= '0;
      w_full_q  <= 1'b0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RespOkay;
    end else begin
      if (aw_hs) begin
        aw_full_q <= 1'b1;
        aw_idx_q  <= bus.awaddr[C_S_AXI_ADDR_WIDTH-1:2];
      end
      if (w_hs) begin
        w_full_q <= 1'b1;
        w_data_q <= bus.wdata;
        w_strb_q <= bus.wstrb;
      end
      if (commit) begin
        aw_full_q <= 1'b0;
        w_full_q  <= 1'b0;
        bvalid_q  <= 1'b1;
        bresp_q   <= rd_err[aw_idx_q] ? RespSlvErr : RespOkay;
      end else if (bvalid_q && bus.bready) begin
        bvalid_q <= 1'b0;
      end
    end
  end

  // Read path: data captured at the AR handshake edge, so a same-edge write is not seen.
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      rvalid_q <= 1'b0;
      rresp_q  <= RespOkay;
      rdata_q  <= '0;
    end else if (ar_hs) begin
      rvalid_q <= 1'b1;
      rresp_q  <= rd_err[ar_idx] ? RespSlvErr : RespOkay;
      rdata_q  <= rd_word[ar_idx];
    end else if (rvalid_q && bus.rready) begin
      rvalid_q <= 1'b0;
    end
  end
endmodule

// File: tb/tb_system_ctl_regbank.sv
// Bench for system_ctl_regbank: directed transactions with literal expectations, then random
// traffic, all shadowed by a cycle-level behavioural model checked every cycle.
module tb_system_ctl_regbank;
  localparam int         NumRegs   = 8;
  localparam logic [3:0] NumIdx4   = 4'd8;
  localparam logic [15:0] RoMask    = 16'h0080;
  localparam logic [15:0] PulseMask = 16'h0040;
`ifdef SYSTEM_CTL_REGBANK_ID_EN
  localparam bit IdEn = 1'b1;
`else
  localparam bit IdEn = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic [NumRegs*32-1:0] ctl_out;
  logic [NumRegs*32-1:0] status_in;
  logic [NumRegs-1:0]    ctl_wr_stb;

  int n_cmp = 0;
  int n_fail = 0;
  int pulse_hits = 0;

  // Behavioural model state.
  logic [31:0] m_regs  [NumRegs];
  logic [31:0] m_pulse [NumRegs];
  logic [7:0]  m_stb;
  logic        m_awh, m_wh, m_bp, m_rp;
  logic [3:0]  m_aw_idx;
  logic [31:0] m_wd;
  logic [3:0]  m_ws;
  logic [1:0]  m_bresp, m_rresp;
  logic [31:0] m_rdata;

  system_ctl_regbank_if #(.ADDR_W(6), .DATA_W(32)) bus ();

  system_ctl_regbank #(
    .C_S_AXI_DATA_WIDTH(32),
    .C_S_AXI_ADDR_WIDTH(6),
    .NUM_REGS(NumRegs),
    .RO_MASK(RoMask),
    .PULSE_MASK(PulseMask),
    .RESET_VALUE(32'h0),
    .ID_VALUE(32'h5C71_0001)
  ) dut (
    .S_AXI_ACLK(clk),
    .S_AXI_ARESET(rst),
    .bus(bus),
    .ctl_out(ctl_out),
    .ctl_wr_stb(ctl_wr_stb),
    .status_in(status_in)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: got no finish want finish before 2ms");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic void rd_model(input logic [3:0] idx, output logic [31:0] d,
                                   output logic [1:0] r);
    d = 32'h0;
    r = 2'b10;
    if (idx < NumIdx4) begin
      r = 2'b00;
      if (RoMask[idx]) d = status_in[32*idx +: 32];
      else if (!PulseMask[idx]) d = m_regs[idx[2:0]];
    end else if (IdEn && idx == NumIdx4) begin
      r = 2'b00;
      d = 32'h5C71_0001;
    end
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NumRegs; i++) begin
      m_regs[i]  = 32'h0;
      m_pulse[i] = 32'h0;
    end
    m_stb = '0;
    {m_awh, m_wh, m_bp, m_rp} = '0;
  endtask

  // Compare DUT against the model on every falling edge, then advance the model.
  task automatic monitor();
    logic [31:0] d, mask, exp_slice;
    logic [1:0]  r;
    logic [3:0]  widx;
    logic        aw_rdy, w_rdy, ar_rdy, commit, do_ar;
    forever begin
      @(negedge clk);
      if (rst) begin
        chk("awready_in_reset", 32'(bus.awready), 32'd0);
        chk("wready_in_reset", 32'(bus.wready), 32'd0);
        chk("arready_in_reset", 32'(bus.arready), 32'd0);
        model_reset();
      end else begin
        aw_rdy = !m_awh && !m_bp;
        w_rdy  = !m_wh && !m_bp;
        ar_rdy = !m_rp;
        chk("awready", 32'(bus.awready), 32'(aw_rdy));
        chk("wready", 32'(bus.wready), 32'(w_rdy));
        chk("arready", 32'(bus.arready), 32'(ar_rdy));
        chk("bvalid", 32'(bus.bvalid), 32'(m_bp));
        chk("rvalid", 32'(bus.rvalid), 32'(m_rp));
        if (m_bp) chk("bresp", 32'(bus.bresp), 32'(m_bresp));
        if (m_rp) begin
          chk("rdata", bus.rdata, m_rdata);
          chk("rresp", 32'(bus.rresp), 32'(m_rresp));
        end
        for (int i = 0; i < NumRegs; i++) begin
          if (RoMask[i]) exp_slice = 32'h0;
          else if (PulseMask[i]) exp_slice = m_pulse[i];
          else exp_slice = m_regs[i];
          chk($sformatf("ctl_out[%0d]", i), ctl_out[32*i +: 32], exp_slice);
        end
        chk("ctl_wr_stb", 32'(ctl_wr_stb), 32'(m_stb));
        if (ctl_out[32*6 +: 32] == 32'h5) pulse_hits++;

        commit = m_awh && m_wh && !m_bp;
        do_ar  = bus.arvalid && ar_rdy;
        if (do_ar) rd_model(bus.araddr[5:2], d, r);
        m_stb = '0;
        for (int i = 0; i < NumRegs; i++) m_pulse[i] = 32'h0;
        if (commit) begin
          widx = m_aw_idx;
          mask = 32'h0;
          for (int b = 0; b < 4; b++) if (m_ws[b]) mask[8*b +: 8] = 8'hFF;
          if (widx < NumIdx4) begin
            m_bresp = 2'b00;
            if (!RoMask[widx]) begin
              m_stb[widx[2:0]] = 1'b1;
              if (PulseMask[widx]) m_pulse[widx[2:0]] = m_wd & mask;
              else m_regs[widx[2:0]] = (m_regs[widx[2:0]] & ~mask) | (m_wd & mask);
            end
          end else if (IdEn && widx == NumIdx4) begin
            m_bresp = 2'b00;
          end else begin
            m_bresp = 2'b10;
          end
          m_bp  = 1'b1;
          m_awh = 1'b0;
          m_wh  = 1'b0;
        end else if (m_bp && bus.bready) begin
          m_bp = 1'b0;
        end
        if (do_ar) begin
          m_rp    = 1'b1;
          m_rdata = d;
          m_rresp = r;
        end else if (m_rp && bus.rready) begin
          m_rp = 1'b0;
        end
        if (bus.awvalid && aw_rdy) begin
          m_awh    = 1'b1;
          m_aw_idx = bus.awaddr[5:2];
        end
        if (bus.wvalid && w_rdy) begin
          m_wh = 1'b1;
          m_wd = bus.wdata;
          m_ws = bus.wstrb;
        end
      end
    end
  endtask

  task automatic do_write(input logic [5:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input int aw_dly, input int w_dly, input int b_dly,
                          output logic [1:0] resp);
    logic got;
    resp = 2'bxx;
    fork
      begin
        logic ok;
        wait_cyc(aw_dly);
        bus.awaddr  = addr;
        bus.awvalid = 1'b1;
        ok = 1'b0;
        for (int k = 0; k < 200 && !ok; k++) begin
          @(negedge clk);
          ok = bus.awready;
          @(posedge clk);
          #1;
        end
        bus.awvalid = 1'b0;
        chk("aw_handshake_timeout", 32'(ok), 32'd1);
      end
      begin
        logic ok;
        wait_cyc(w_dly);
        bus.wdata  = data;
        bus.wstrb  = strb;
        bus.wvalid = 1'b1;
        ok = 1'b0;
        for (int k = 0; k < 200 && !ok; k++) begin
          @(negedge clk);
          ok = bus.wready;
          @(posedge clk);
          #1;
        end
        bus.wvalid = 1'b0;
        chk("w_handshake_timeout", 32'(ok), 32'd1);
      end
    join
    wait_cyc(b_dly);
    bus.bready = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 200 && !got; k++) begin
      @(negedge clk);
      if (bus.bvalid) begin
        got  = 1'b1;
        resp = bus.bresp;
      end
      @(posedge clk);
      #1;
    end
    bus.bready = 1'b0;
    chk("b_timeout", 32'(got), 32'd1);
  endtask

  task automatic do_read(input logic [5:0] addr, input int ar_dly, input int r_dly,
                         output logic [31:0] data, output logic [1:0] resp);
    logic ok;
    data = 32'hx;
    resp = 2'bxx;
    wait_cyc(ar_dly);
    bus.araddr  = addr;
    bus.arvalid = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 200 && !ok; k++) begin
      @(negedge clk);
      ok = bus.arready;
      @(posedge clk);
      #1;
    end
    bus.arvalid = 1'b0;
    chk("ar_handshake_timeout", 32'(ok), 32'd1);
    wait_cyc(r_dly);
    bus.rready = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 200 && !ok; k++) begin
      @(negedge clk);
      if (bus.rvalid) begin
        ok   = 1'b1;
        data = bus.rdata;
        resp = bus.rresp;
      end
      @(posedge clk);
      #1;
    end
    bus.rready = 1'b0;
    chk("r_timeout", 32'(ok), 32'd1);
  endtask

  initial begin
    logic [31:0] d;
    logic [1:0]  r;
    logic        seen;
    int          base;
    logic [31:0] wr_vals [4];
    wr_vals = '{32'h0101_FFFF, 32'hABCD_0001, 32'hDEAD_0011, 32'hBEEF_0011};

    rst = 1'b1;
    bus.awaddr = '0; bus.awprot = '0; bus.awvalid = 1'b0;
    bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0; bus.bready = 1'b0;
    bus.araddr = '0; bus.arprot = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;
    status_in = '0;
    status_in[32*7 +: 32] = 32'h1234_5678;
    status_in[32*2 +: 32] = 32'hCAFE_F00D;
    model_reset();
    fork
      monitor();
    join_none
    wait_cyc(4);
    rst = 1'b0;

    @(negedge clk);
    chk("reset_rdata", bus.rdata, 32'h0);
    chk("reset_rresp", 32'(bus.rresp), 32'd0);
    chk("reset_bresp", 32'(bus.bresp), 32'd0);
    @(posedge clk);
    #1;

    // Every register after reset; reg 7 mirrors its status word.
    for (int i = 0; i < NumRegs; i++) begin
      do_read(6'(4*i), 0, 0, d, r);
      chk($sformatf("reset_read[%0d]", i), d, (i == 7) ? 32'h1234_5678 : 32'h0);
      chk($sformatf("reset_rresp[%0d]", i), 32'(r), 32'd0);
    end

    for (int i = 0; i < 4; i++) begin
      do_write(6'(4*i), wr_vals[i], 4'hF, 0, 0, 0, r);
      chk($sformatf("wr_bresp[%0d]", i), 32'(r), 32'd0);
    end
    for (int i = 0; i < 4; i++) begin
      do_read(6'(4*i), 0, 1, d, r);
      chk($sformatf("readback[%0d]", i), d, wr_vals[i]);
    end

    // W leads AW by three cycles, only byte 1 enabled.
    do_write(6'h04, 32'h0000_AA00, 4'b0010, 3, 0, 0, r);
    chk("w_first_bresp", 32'(r), 32'd0);
    do_read(6'h04, 0, 0, d, r);
    chk("w_first_merge", d, 32'hABCD_AA01);

    do_write(6'h1C, 32'hFFFF_FFFF, 4'hF, 0, 0, 0, r);
    chk("ro_write_bresp", 32'(r), 32'd0);
    do_read(6'h1C, 0, 0, d, r);
    chk("ro_read", d, 32'h1234_5678);

    base = pulse_hits;
    do_write(6'h18, 32'h0000_0005, 4'hF, 0, 0, 0, r);
    wait_cyc(3);
    chk("pulse_cycles", 32'(pulse_hits - base), 32'd1);
    do_read(6'h18, 0, 0, d, r);
    chk("pulse_read", d, 32'h0);

    do_write(6'h30, 32'h5555_5555, 4'hF, 1, 0, 0, r);
    chk("unmapped_bresp", 32'(r), 32'd2);
    do_read(6'h30, 0, 0, d, r);
    chk("unmapped_rdata", d, 32'h0);
    chk("unmapped_rresp", 32'(r), 32'd2);
    do_read(6'h20, 0, 0, d, r);
    chk("id_rdata", d, IdEn ? 32'h5C71_0001 : 32'h0);
    chk("id_rresp", 32'(r), IdEn ? 32'd0 : 32'd2);

    // Hold BREADY low and watch the response stay parked.
    fork
      do_write(6'h08, 32'h1111_2222, 4'hF, 0, 0, 14, r);
      begin
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
          @(negedge clk);
          seen = bus.bvalid;
        end
        chk("bhold_seen", 32'(seen), 32'd1);
        for (int k = 0; k < 10; k++) begin
          if (k > 0) @(negedge clk);
          chk("bhold_bvalid", 32'(bus.bvalid), 32'd1);
          chk("bhold_bresp", 32'(bus.bresp), 32'd0);
          chk("bhold_awready", 32'(bus.awready), 32'd0);
        end
      end
    join
    do_read(6'h08, 0, 0, d, r);
    chk("bhold_readback", d, 32'h1111_2222);

    // Random concurrent traffic; the monitor carries the checking.
    fork
      begin
        logic [1:0] wr;
        for (int k = 0; k < 80; k++) begin
          do_write(6'($urandom_range(0, 63)), $urandom, 4'($urandom), $urandom_range(0, 3),
                   $urandom_range(0, 3), $urandom_range(0, 2), wr);
        end
      end
      begin
        logic [31:0] rd;
        logic [1:0]  rr;
        for (int k = 0; k < 80; k++) begin
          for (int i = 0; i < NumRegs; i++) status_in[32*i +: 32] = $urandom;
          do_read(6'($urandom_range(0, 63)), $urandom_range(0, 3), $urandom_range(0, 2), rd, rr);
        end
      end
    join

    wait_cyc(3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
